cuckoo_insert_ctrl: RTL and testbench

- Front-end insert controller for the cuckoo hash table. It sits directly upstream of the first column and closes the cuckoo loop.
- Accepts new key/value inserts over a valid/ready handshake and presents them to the first column's eviction input.
- Re-injects evictions returned from the last column, counting kicks. Declares an insert complete after a quiet window with no returned eviction, or failed after MAX_KICKS.
- Exactly one insert chain is in flight at a time. Lookups pass through untouched and take priority.

---
 rtl/hashmap_pkg.sv | 27 ++
 rtl/cuckoo_insert_ctrl_if.sv | 39 +++
 rtl/cuckoo_stats.sv | 27 ++
 rtl/cuckoo_insert_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cuckoo_insert_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hashmap_pkg.sv
// Shared types and sizing helpers for the cuckoo hash table front end.
package hashmap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } ins_state_e;

    localparam int unsigned STAT_W = 32;

    // Kick counter must represent 0..max_kicks inclusive.
    function automatic int unsigned kick_width(input int unsigned max_kicks);
        return (max_kicks > 0) ? $clog2(max_kicks + 1) : 1;
    endfunction

    function automatic int unsigned quiet_width(input int unsigned quiet_cycles);
        return (quiet_cycles > 1) ? $clog2(quiet_cycles) : 1;
    endfunction

    // Smallest quiet window that outlasts one trip around the column loop.
    function automatic int unsigned quiet_cycles_default(input int unsigned num_cols,
                                                         input int unsigned num_pipes);
        return num_cols * num_pipes + 1;
    endfunction

endpackage

// File: rtl/cuckoo_insert_ctrl_if.sv
// Insert/eviction bus between the insert controller, its client and the column loop.
interface cuckoo_insert_ctrl_if #(
    parameter int unsigned NUM_KEY_BITS = 8,
    parameter int unsigned NUM_VAL_BITS = 8
);
    logic                    ins_valid;
    logic                    ins_ready;
    logic [NUM_KEY_BITS-1:0] ins_key;
    logic [NUM_VAL_BITS-1:0] ins_value;
    logic                    col_lookup;
    logic                    col_busy;
    logic                    col_ev_valid;
    logic [NUM_KEY_BITS-1:0] col_ev_key;
    logic [NUM_VAL_BITS-1:0] col_ev_value;
    logic                    ev_ret_valid;
    logic [NUM_KEY_BITS-1:0] ev_ret_key;
    logic [NUM_VAL_BITS-1:0] ev_ret_value;
    logic                    done;
    logic                    fail;
    logic [NUM_KEY_BITS-1:0] ovf_key;
    logic [NUM_VAL_BITS-1:0] ovf_value;
    logic                    err;

    // Controller side.
    modport slave (
        input  ins_valid, ins_key, ins_value, col_lookup, col_busy,
               ev_ret_valid, ev_ret_key, ev_ret_value,
        output ins_ready, col_ev_valid, col_ev_key, col_ev_value,
               done, fail, ovf_key, ovf_value, err
    );

    // Client / table side.
    modport master (
        output ins_valid, ins_key, ins_value, col_lookup, col_busy,
               ev_ret_valid, ev_ret_key, ev_ret_value,
        input  ins_ready, col_ev_valid, col_ev_key, col_ev_value,
               done, fail, ovf_key, ovf_value, err
    );
endinterface

// File: rtl/cuckoo_stats.sv
// Free-running insert/kick/fail counters for the insert controller (CUCKOO_STATS_EN builds).
module cuckoo_stats
    import hashmap_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_insert,
    input  logic              inc_kick,
    input  logic              inc_fail,
    output logic [STAT_W-1:0] stat_inserts,
    output logic [STAT_W-1:0] stat_kicks,
    output logic [STAT_W-1:0] stat_fails
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_inserts <= '0;
            stat_kicks   <= '0;
            stat_fails   <= '0;
        end else begin
            if (inc_insert) stat_inserts <= stat_inserts + STAT_W'(1);
            if (inc_kick)   stat_kicks   <= stat_kicks + STAT_W'(1);
            if (inc_fail)   stat_fails   <= stat_fails + STAT_W'(1);
        end
    end

endmodule

// File: rtl/cuckoo_insert_ctrl.sv
// Cuckoo insert controller: feeds new inserts and returned evictions into the first column.
// Define CUCKOO_STATS_EN to add the stat_inserts/stat_kicks/stat_fails counters.
module cuckoo_insert_ctrl
    import hashmap_pkg::*;
#(
    parameter int unsigned NUM_KEY_BITS = 8,
    parameter int unsigned NUM_VAL_BITS = 8,
    parameter int unsigned MAX_KICKS    = 16,
    parameter int unsigned QUIET_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    cuckoo_insert_ctrl_if.slave bus
`ifdef CUCKOO_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_inserts,
    output logic [STAT_W-1:0] stat_kicks,
    output logic [STAT_W-1:0] stat_fails
`endif
);

    localparam int unsigned KICK_W  = kick_width(MAX_KICKS);
    localparam int unsigned QUIET_W = quiet_width(QUIET_CYCLES);
    localparam logic [KICK_W-1:0]  KICK_MAX   = KICK_W'(MAX_KICKS);
    localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);

    ins_state_e state_q, state_d;

    logic [NUM_KEY_BITS-1:0] hold_key_q, hold_key_d;
    logic [NUM_VAL_BITS-1:0] hold_val_q, hold_val_d;
    logic [KICK_W-1:0]       kick_q, kick_d;
    logic [QUIET_W-1:0]      quiet_q, quiet_d;
    logic                    ev_valid_q, ev_valid_d;
    logic                    done_q, done_d;
    logic                    fail_q, fail_d;
    logic                    err_q, err_d;
    logic [NUM_KEY_BITS-1:0] ovf_key_q, ovf_key_d;
    logic [NUM_VAL_BITS-1:0] ovf_val_q, ovf_val_d;

    logic stall;
    logic accept;
    logic kick_max;
    logic quiet_last;
    logic reinject;

    // Lookups and column busy both block acceptance and freeze the quiet window.
    assign stall      = bus.col_busy | bus.col_lookup;
    assign accept     = ev_valid_q & ~stall;
    assign kick_max   = (kick_q == KICK_MAX);
    assign quiet_last = (quiet_q == QUIET_LAST);
    assign reinject   = (state_q == WAIT) & bus.ev_ret_valid & ~kick_max;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.ins_valid) state_d = ISSUE;
            ISSUE:   if (accept) state_d = WAIT;
            WAIT: begin
                if (bus.ev_ret_valid)           state_d = kick_max ? IDLE : ISSUE;
                else if (!stall && quiet_last)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_key_d = hold_key_q;
        hold_val_d = hold_val_q;
        kick_d     = kick_q;
        quiet_d    = quiet_q;
        done_d     = 1'b0;
        fail_d     = 1'b0;
        ovf_key_d  = ovf_key_q;
        ovf_val_d  = ovf_val_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ins_valid) begin
                    hold_key_d = bus.ins_key;
                    hold_val_d = bus.ins_value;
                    kick_d     = '0;
                end
                if (bus.ev_ret_valid) err_d = 1'b1;
            end
            ISSUE: begin
                if (accept) quiet_d = '0;
                if (bus.ev_ret_valid) err_d = 1'b1;
            end
            WAIT: begin
                if (bus.ev_ret_valid && kick_max) begin
                    ovf_key_d = bus.ev_ret_key;
                    ovf_val_d = bus.ev_ret_value;
                    fail_d    = 1'b1;
                end else if (reinject) begin
                    hold_key_d = bus.ev_ret_key;
                    hold_val_d = bus.ev_ret_value;
                    kick_d     = kick_q + KICK_W'(1);
                end else if (!stall) begin
                    if (quiet_last) done_d = 1'b1;
                    else            quiet_d = quiet_q + QUIET_W'(1);
                end
            end
            default: ;
        endcase
        ev_valid_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_key_q <= '0;
            hold_val_q <= '0;
            kick_q     <= '0;
            quiet_q    <= '0;
            ev_valid_q <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            err_q      <= 1'b0;
            ovf_key_q  <= '0;
            ovf_val_q  <= '0;
        end else begin
            hold_key_q <= hold_key_d;
            hold_val_q <= hold_val_d;
            kick_q     <= kick_d;
            quiet_q    <= quiet_d;
            ev_valid_q <= ev_valid_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
            ovf_key_q  <= ovf_key_d;
            ovf_val_q  <= ovf_val_d;
        end
    end

    // Ready must drop in the reset cycle itself, so it cannot wait for a register.
    assign bus.ins_ready    = (state_q == IDLE) & ~rst;
    assign bus.col_ev_valid = ev_valid_q;
    assign bus.col_ev_key   = hold_key_q;
    assign bus.col_ev_value = hold_val_q;
    assign bus.done         = done_q;
    assign bus.fail         = fail_q;
    assign bus.ovf_key      = ovf_key_q;
    assign bus.ovf_value    = ovf_val_q;
    assign bus.err          = err_q;

`ifdef CUCKOO_STATS_EN
    cuckoo_stats u_stats (
        .clk          (clk),
        .rst          (rst),
        .inc_insert   (done_d | fail_d),
        .inc_kick     (reinject),
        .inc_fail     (fail_d),
        .stat_inserts (stat_inserts),
        .stat_kicks   (stat_kicks),
        .stat_fails   (stat_fails)
    );
`endif

endmodule

// File: tb/tb_cuckoo_insert_ctrl.sv
// Bench for cuckoo_insert_ctrl: directed scenarios plus random chains against a transaction-level model.
module tb_cuckoo_insert_ctrl;

    localparam int MAXK = 4;
    localparam int QC   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cuckoo_insert_ctrl_if #(.NUM_KEY_BITS(8), .NUM_VAL_BITS(8)) bus ();

`ifdef CUCKOO_STATS_EN
    logic [31:0] stat_inserts, stat_kicks, stat_fails;
`endif

    cuckoo_insert_ctrl #(
        .NUM_KEY_BITS (8),
        .NUM_VAL_BITS (8),
        .MAX_KICKS    (MAXK),
        .QUIET_CYCLES (QC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef CUCKOO_STATS_EN
        ,
        .stat_inserts (stat_inserts),
        .stat_kicks   (stat_kicks),
        .stat_fails   (stat_fails)
`endif
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model state: expected sticky error and statistic totals.
    bit exp_err = 0;
    int m_ins = 0, m_kicks = 0, m_fails = 0;

    // Planned returns for the next chain: key, value, unstalled WAIT cycles before returning.
    logic [7:0] rk_q[$];
    logic [7:0] rv_q[$];
    int         rd_q[$];
    int         issue_busy = -1;
    int         lookup_pct = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plan_ret(input logic [7:0] k, input logic [7:0] v, input int d);
        rk_q.push_back(k);
        rv_q.push_back(v);
        rd_q.push_back(d);
    endtask

    // Drive one insert chain; the model: each return before the (MAXK+1)th becomes the next
    // issued pair, the (MAXK+1)th is dropped via fail, otherwise done after QC unstalled cycles.
    task automatic do_chain(input logic [7:0] key, input logic [7:0] val);
        int cyc, u, target, stalls, nk;
        bit finished, stl;
        logic [7:0] ck, cv, rk, rv;
        cyc = 0;
        while (bus.ins_ready !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("ready_before_insert", 32'(bus.ins_ready), 1);
        bus.ins_valid = 1'b1;
        bus.ins_key   = key;
        bus.ins_value = val;
        tick();
        bus.ins_valid = 1'b0;
        ck = key; cv = val; nk = 0; finished = 0;
        while (!finished) begin
            chk("issue_valid", 32'(bus.col_ev_valid), 1);
            chk("issue_key", 32'(bus.col_ev_key), 32'(ck));
            chk("issue_value", 32'(bus.col_ev_value), 32'(cv));
            chk("issue_not_ready", 32'(bus.ins_ready), 0);
            stalls = (issue_busy < 0) ? int'($urandom_range(0, 3)) : issue_busy;
            for (int s = 0; s < stalls; s++) begin
                if (issue_busy >= 0 || $urandom_range(0, 1) == 1) bus.col_busy = 1'b1;
                else bus.col_lookup = 1'b1;
                tick();
                bus.col_busy = 1'b0;
                bus.col_lookup = 1'b0;
                chk("stall_hold_valid", 32'(bus.col_ev_valid), 1);
                chk("stall_hold_key", 32'(bus.col_ev_key), 32'(ck));
                chk("stall_hold_value", 32'(bus.col_ev_value), 32'(cv));
            end
            tick();
            chk("accepted_drop_valid", 32'(bus.col_ev_valid), 0);
            u = 0;
            cyc = 0;
            if (rk_q.size() > 0) begin
                target = rd_q.pop_front();
                rk = rk_q.pop_front();
                rv = rv_q.pop_front();
                while (u < target) begin
                    stl = (cyc < 100) && ($urandom_range(0, 99) < lookup_pct);
                    bus.col_lookup = stl;
                    tick();
                    bus.col_lookup = 1'b0;
                    cyc++;
                    if (!stl) u++;
                    chk("wait_no_done", 32'(bus.done), 0);
                end
                bus.ev_ret_valid = 1'b1;
                bus.ev_ret_key   = rk;
                bus.ev_ret_value = rv;
                tick();
                bus.ev_ret_valid = 1'b0;
                if (nk == MAXK) begin
                    chk("fail_pulse", 32'(bus.fail), 1);
                    chk("fail_ovf_key", 32'(bus.ovf_key), 32'(rk));
                    chk("fail_ovf_value", 32'(bus.ovf_value), 32'(rv));
                    chk("fail_no_done", 32'(bus.done), 0);
                    chk("fail_ready", 32'(bus.ins_ready), 1);
                    m_fails++;
                    m_ins++;
                    finished = 1;
                end else begin
                    chk("kick_no_fail", 32'(bus.fail), 0);
                    nk++;
                    m_kicks++;
                    ck = rk;
                    cv = rv;
                end
            end else begin
                while (u < QC) begin
                    stl = (cyc < 100) && ($urandom_range(0, 99) < lookup_pct);
                    bus.col_lookup = stl;
                    tick();
                    bus.col_lookup = 1'b0;
                    cyc++;
                    if (!stl) u++;
                    chk("done_timing", 32'(bus.done), (u == QC) ? 1 : 0);
                end
                chk("done_ready", 32'(bus.ins_ready), 1);
                chk("done_no_fail", 32'(bus.fail), 0);
                m_ins++;
                finished = 1;
            end
            chk("err_level", 32'(bus.err), 32'(exp_err));
        end
        tick();
        chk("single_done", 32'(bus.done), 0);
        chk("single_fail", 32'(bus.fail), 0);
        rk_q.delete();
        rv_q.delete();
        rd_q.delete();
    endtask

    initial begin
        int n;
        bus.ins_valid = 0; bus.ins_key = 0; bus.ins_value = 0;
        bus.col_lookup = 0; bus.col_busy = 0;
        bus.ev_ret_valid = 0; bus.ev_ret_key = 0; bus.ev_ret_value = 0;

        // Reset state
        tick(); tick();
        chk("rst_ready_low", 32'(bus.ins_ready), 0);
        rst = 1'b0;
        #1;
        chk("rst_ev_valid", 32'(bus.col_ev_valid), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_fail", 32'(bus.fail), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_ovf_key", 32'(bus.ovf_key), 0);
        chk("rst_ovf_value", 32'(bus.ovf_value), 0);
        chk("idle_ready", 32'(bus.ins_ready), 1);

        // Plain insert, no returns
        issue_busy = 0; lookup_pct = 0;
        do_chain(8'h12, 8'h34);

        // One return three cycles after accept
        plan_ret(8'h55, 8'h66, 3);
        do_chain(8'h12, 8'h34);

        // Back-to-back returns exhaust the kick budget
        for (int i = 0; i <= MAXK; i++) plan_ret(8'(8'hA0 + i), 8'(8'hB0 + i), 0);
        do_chain(8'h77, 8'h88);

        // Busy during ISSUE, lookups during WAIT
        issue_busy = 5; lookup_pct = 30;
        plan_ret(8'h3C, 8'h4D, 2);
        do_chain(8'h21, 8'h43);

        // Stray return while idle
        bus.ev_ret_valid = 1'b1; bus.ev_ret_key = 8'hEE; bus.ev_ret_value = 8'hDD;
        tick();
        bus.ev_ret_valid = 1'b0;
        exp_err = 1;
        chk("stray_err", 32'(bus.err), 1);
        chk("stray_ready", 32'(bus.ins_ready), 1);
        chk("stray_ev_valid", 32'(bus.col_ev_valid), 0);
        chk("stray_done", 32'(bus.done), 0);
        chk("stray_fail", 32'(bus.fail), 0);
        tick();
        chk("stray_err_sticky", 32'(bus.err), 1);

        // Reset mid-WAIT after two kicks
        bus.ins_valid = 1'b1; bus.ins_key = 8'hA1; bus.ins_value = 8'hB1;
        tick();
        bus.ins_valid = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.ev_ret_valid = 1'b1; bus.ev_ret_key = 8'(8'hC0 + k); bus.ev_ret_value = 8'(8'hD0 + k);
            tick();
            bus.ev_ret_valid = 1'b0;
            chk("abort_reinject_key", 32'(bus.col_ev_key), 32'(8'hC0 + k));
            tick();
        end
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort_rst_ready_low", 32'(bus.ins_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        exp_err = 0; m_ins = 0; m_kicks = 0; m_fails = 0;
        chk("abort_ready", 32'(bus.ins_ready), 1);
        chk("abort_ev_valid", 32'(bus.col_ev_valid), 0);
        chk("abort_err_clear", 32'(bus.err), 0);
        for (int c = 0; c < QC + 2; c++) begin
            chk("abort_no_pulse", 32'(bus.done | bus.fail), 0);
            tick();
        end
        issue_busy = 0; lookup_pct = 0;
        for (int i = 0; i < MAXK; i++) plan_ret(8'(8'h60 + i), 8'(8'h70 + i), 1);
        do_chain(8'h5A, 8'hA5);

        // Random chains
        issue_busy = -1; lookup_pct = 25;
        for (int t = 0; t < 20; t++) begin
            n = int'($urandom_range(0, MAXK + 1));
            for (int i = 0; i < n; i++)
                plan_ret(8'($urandom), 8'($urandom), int'($urandom_range(0, QC - 1)));
            do_chain(8'($urandom), 8'($urandom));
        end

`ifdef CUCKOO_STATS_EN
        chk("stat_inserts", stat_inserts, 32'(m_ins));
        chk("stat_kicks", stat_kicks, 32'(m_kicks));
        chk("stat_fails", stat_fails, 32'(m_fails));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
